// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator for the UART TX/RX engines.
// A prescaler divides clk by (div_q+1) to form the oversample tick. A phase
// counter divides that by OS to give mid-bit and bit-end strobes.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   en            : count enable; counters hold and pulses are suppressed when low
//   sync          : restart prescaler and phase, e.g. on an RX start-bit edge
//   div_load      : load div_in into the divisor, restarting like sync
//   div_in        : new divisor; prescale period is div_in+1 clocks
//   div_q         : current divisor readback
//   os_tick       : oversample tick, one-cycle pulse
//   bit_mid       : mid-bit strobe (RX sample point), coincident with os_tick
//   bit_end       : bit-boundary strobe (TX shift point), coincident with os_tick
//   phase         : oversample phase within the current bit
module baud_tick_gen #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned OS          = 16,
  parameter int unsigned DEFAULT_DIV = 650,
  localparam int unsigned PH_W       = $clog2(OS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  output logic [DIV_W-1:0] div_q,
  output logic             os_tick,
  output logic             bit_mid,
  output logic             bit_end,
  output logic [PH_W-1:0]  phase
);

  // Phase values from which the next wrap raises bit_mid / bit_end.
  localparam logic [PH_W-1:0] MID_FROM = PH_W'(OS / 2 - 1);
  localparam logic [PH_W-1:0] END_FROM = PH_W'(OS - 1);

  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_mid_q, bit_mid_d;
  logic             bit_end_q, bit_end_d;
  logic [DIV_W-1:0] div_r;

  // Next-state: div_load > sync > enabled count; pulses default low.
  always_comb begin
    div_d     = div_r;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    os_tick_d = 1'b0;
    bit_mid_d = 1'b0;
    bit_end_d = 1'b0;
    if (div_load) begin
      div_d   = div_in;
      cnt_d   = '0;
      phase_d = '0;
    end else if (sync) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (en) begin
      if (cnt_q == div_r) begin
        // Wrap event: counter never exceeds div_r, so all-ones is safe.
        cnt_d     = '0;
        phase_d   = phase_q + PH_W'(1);
        os_tick_d = 1'b1;
        bit_mid_d = (phase_q == MID_FROM);
        bit_end_d = (phase_q == END_FROM);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r     <= DIV_W'(DEFAULT_DIV);
      cnt_q     <= '0;
      phase_q   <= '0;
      os_tick_q <= 1'b0;
      bit_mid_q <= 1'b0;
      bit_end_q <= 1'b0;
    end else begin
      div_r     <= div_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      os_tick_q <= os_tick_d;
      bit_mid_q <= bit_mid_d;
      bit_end_q <= bit_end_d;
    end
  end

  assign div_q   = div_r;
  assign os_tick = os_tick_q;
  assign bit_mid = bit_mid_q;
  assign bit_end = bit_end_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Testbench for baud_tick_gen: per-cycle expectations from an arithmetic model
// are queued by the driver and popped by an independent monitor.
module tb_baud_tick_gen;

  localparam int unsigned DIV_W       = 16;
  localparam int unsigned OS          = 16;
  localparam int unsigned PH_W        = 4;
  localparam int unsigned DEFAULT_DIV = 650;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             sync = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic [DIV_W-1:0] div_q;
  logic             os_tick, bit_mid, bit_end;
  logic [PH_W-1:0]  phase;

  always #5 clk = ~clk;

  baud_tick_gen #(.DIV_W(DIV_W), .OS(OS), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .div_load(div_load),
    .div_in(div_in), .div_q(div_q), .os_tick(os_tick), .bit_mid(bit_mid),
    .bit_end(bit_end), .phase(phase)
  );

  typedef struct {
    logic [DIV_W-1:0] div;
    logic             os;
    logic             mid;
    logic             fin;
    logic [PH_W-1:0]  ph;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: divisor plus count of enabled cycles since the last restart.
  longint m_div = DEFAULT_DIV;
  longint m_n   = 0;

  logic             obs_os, obs_mid, obs_end;
  logic [PH_W-1:0]  obs_ph;
  logic [DIV_W-1:0] obs_div;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // One clock: drive inputs, predict post-edge outputs, capture them after the edge.
  task automatic step(input logic r, input logic e, input logic s, input logic l,
                      input logic [DIV_W-1:0] d);
    exp_t   x;
    longint p, t;
    @(negedge clk); #1;
    rst = r; en = e; sync = s; div_load = l; div_in = d;
    x.os = 1'b0; x.mid = 1'b0; x.fin = 1'b0;
    if (r) begin
      m_div = DEFAULT_DIV; m_n = 0;
    end else if (l) begin
      m_div = longint'(d); m_n = 0;
    end else if (s) begin
      m_n = 0;
    end else if (e) begin
      m_n++;
      p = m_div + 1;
      if (m_n % p == 0) begin
        t     = m_n / p;
        x.os  = 1'b1;
        x.mid = (t % OS == OS / 2);
        x.fin = (t % OS == 0);
      end
    end
    p     = m_div + 1;
    x.ph  = PH_W'((m_n / p) % OS);
    x.div = DIV_W'(m_div);
    exp_q.push_back(x);
    @(posedge clk); #1;
    obs_os = os_tick; obs_mid = bit_mid; obs_end = bit_end;
    obs_ph = phase;   obs_div = div_q;
  endtask

  // Monitor: compare the DUT against the queued prediction every cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("sb_os_tick", os_tick, x.os);
        check("sb_bit_mid", bit_mid, x.mid);
        check("sb_bit_end", bit_end, x.fin);
        check("sb_phase",   phase,   x.ph);
        check("sb_div_q",   div_q,   x.div);
        check("sb_mid_end_overlap", bit_mid & bit_end, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_os, first_mid, first_end, k, cnt_os, cnt_end, cnt_pulse;
    int mids[$], ends[$];
    bit found;

    // Reset held 3 cycles with en high, then default-divisor latency.
    repeat (3) step(1, 1, 0, 0, '0);
    check("reset_div_q", obs_div, DEFAULT_DIV);
    check("reset_pulses", {obs_os, obs_mid, obs_end}, 0);
    first_os = -1; first_mid = -1; first_end = -1;
    for (int i = 1; i <= 10416; i++) begin
      step(0, 1, 0, 0, '0);
      if (obs_os  && first_os  < 0) first_os  = i;
      if (obs_mid && first_mid < 0) first_mid = i;
      if (obs_end && first_end < 0) first_end = i;
    end
    check("first_os_tick", first_os, 651);
    check("first_bit_mid", first_mid, 5208);
    check("first_bit_end", first_end, 10416);

    // Runtime divisor of 3.
    step(0, 1, 0, 1, 16'd3);
    check("load_div_q", obs_div, 3);
    for (int i = 1; i <= 170; i++) begin
      step(0, 1, 0, 0, '0);
      if (obs_mid) mids.push_back(i);
      if (obs_end) ends.push_back(i);
    end
    check("load_mid0", at(mids, 0), 32);
    check("load_mid1", at(mids, 1), 96);
    check("load_mid2", at(mids, 2), 160);
    check("load_end0", at(ends, 0), 64);
    check("load_end1", at(ends, 1), 128);

    // Resync 10 clocks after a bit_end.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(0, 1, 0, 0, '0);
      found = obs_end;
    end
    check("resync_found_bit_end", found, 1);
    repeat (9) step(0, 1, 0, 0, '0);
    step(0, 1, 1, 0, '0);
    check("resync_phase", obs_ph, 0);
    check("resync_no_pulse", {obs_os, obs_mid, obs_end}, 0);
    first_mid = -1; first_end = -1;
    for (int i = 1; i <= 70; i++) begin
      step(0, 1, 0, 0, '0);
      if (obs_mid && first_mid < 0) first_mid = i;
      if (obs_end && first_end < 0) first_end = i;
    end
    check("resync_mid", first_mid, 32);
    check("resync_end", first_end, 64);

    // Enable gating at phase 5, prescaler 2.
    step(0, 1, 0, 1, 16'd3);
    repeat (22) step(0, 1, 0, 0, '0);
    check("gate_phase_before", obs_ph, 5);
    cnt_pulse = 0;
    repeat (7) begin
      step(0, 0, 0, 0, '0);
      cnt_pulse += int'(obs_os) + int'(obs_mid) + int'(obs_end);
    end
    check("gate_no_pulses", cnt_pulse, 0);
    check("gate_phase_held", obs_ph, 5);
    k = -1;
    for (int i = 1; i <= 10 && k < 0; i++) begin
      step(0, 1, 0, 0, '0);
      if (obs_os) k = i;
    end
    check("gate_resume_tick", k, 2);

    // Divisor of zero.
    step(0, 1, 0, 1, 16'd0);
    cnt_os = 0; cnt_end = 0;
    repeat (32) begin
      step(0, 1, 0, 0, '0);
      cnt_os  += int'(obs_os);
      cnt_end += int'(obs_end);
    end
    check("div0_os_count", cnt_os, 32);
    check("div0_end_count", cnt_end, 2);

    // Load and sync together.
    step(0, 1, 1, 1, 16'd5);
    check("ldsync_div_q", obs_div, 5);
    check("ldsync_phase", obs_ph, 0);
    check("ldsync_no_pulse", {obs_os, obs_mid, obs_end}, 0);
    repeat (20) step(0, 1, 0, 0, '0);

    // Reset on the cycle a bit_end is due.
    step(0, 1, 0, 1, 16'd3);
    repeat (63) step(0, 1, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    check("rst_due_bit_end", obs_end, 0);
    check("rst_due_phase", obs_ph, 0);
    check("rst_due_div_q", obs_div, DEFAULT_DIV);

    // All-ones divisor.
    step(0, 1, 0, 1, 16'hFFFF);
    repeat (5) step(0, 1, 0, 0, '0);
    check("allones_div_q", obs_div, 16'hFFFF);

    // Randomized traffic with small divisors.
    step(0, 1, 0, 1, 16'd2);
    for (int i = 0; i < 3000; i++) begin
      logic r, e, s, l;
      logic [DIV_W-1:0] d;
      r = ($urandom_range(0, 499) == 0);
      e = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 149) == 0);
      d = DIV_W'($urandom_range(0, 7));
      step(r, e, s, l, d);
    end

    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised baud-rate tick generator for the UART TX/RX blocks.
- Supports a runtime-loadable divisor, an oversampling tick, mid-bit and bit-end strobes, enable/hold, and phase resynchronisation so the receiver can align to a detected start-bit edge.
- Sits between the 100 MHz system clock domain logic and the UART shift engines. It is a single clock domain block.

Parameters:
- DIV_W, 16: width of the divisor register and the prescale counter.
- OS, 16: oversampling factor, in oversample ticks per bit. Legal values are powers of 2 from 2 to 64.
- DEFAULT_DIV, 650: divisor after reset. 100e6/(9600*16) - 1 = 650, which gives 9600 baud at x16 oversampling.

Ports:
- clk  in  1  system clock, 100 MHz nominal.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable. When low, the counters hold.
- sync  in  1  phase restart pulse, e.g. on an RX start-bit falling edge.
- div_load  in  1  load strobe for div_in.
- div_in  in  DIV_W  new divisor value. Prescale period is div_in+1 clocks.
- div_q  out  DIV_W  current divisor (readback).
- os_tick  out  1  oversample tick, one-cycle pulse.
- bit_mid  out  1  mid-bit strobe, one-cycle pulse. Used as the RX sample point.
- bit_end  out  1  bit-boundary strobe, one-cycle pulse. Used as the TX shift point.
- phase  out  log2(OS)  current oversample phase within a bit.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - div_q = DEFAULT_DIV
  - prescale counter = 0
  - phase = 0
  - os_tick = 0, bit_mid = 0, bit_end = 0
- Reset applied mid-operation clears everything on the next clk edge. Any pulse in flight is dropped.
- Prescaler operation, with D = div_q:
  - The prescale counter counts 0..D while en=1.
  - When the counter equals D, the next edge wraps it to 0 and registers os_tick=1 for exactly one cycle.
  - os_tick period is therefore D+1 clocks.
  - D=0 is legal: os_tick is then high every cycle.
- Phase counter:
  - Increments modulo OS on each internal wrap event.
  - bit_mid=1 on the wrap that moves phase from OS/2-1 to OS/2.
  - bit_end=1 on the wrap that moves phase from OS-1 to 0.
  - bit_mid and bit_end are coincident with os_tick. They are never both high in the same cycle.
- Latency: with en held high from reset release, the first os_tick is at cycle D+1.
  - First bit_mid is at cycle (OS/2)*(D+1). bit_mid then repeats every OS*(D+1) clocks.
  - First bit_end is at cycle OS*(D+1). bit_end then repeats every OS*(D+1) clocks.
- en=0:
  - The prescaler and phase counter hold their values.
  - All pulse outputs are 0.
  - When en returns high, counting resumes from the held values, with no extra or skipped tick.
- sync=1, which acts regardless of en:
  - On the next edge the prescaler and phase clear to 0.
  - No pulse is generated in that cycle, even if a wrap was due.
  - The next os_tick follows D+1 enabled cycles after the sync cycle.
  - The next bit_mid follows (OS/2)*(D+1) enabled cycles after the sync cycle.
- div_load=1:
  - div_q <= div_in on the next edge.
  - The prescaler and phase clear to 0, the same as sync.
  - No pulse is generated that cycle.
- Simultaneous events use this priority: rst > div_load > sync > normal count.
  - When div_load and sync are both high, the divisor is loaded and the phase restarted once.
- Widths:
  - The prescaler is a DIV_W-bit unsigned counter and never exceeds div_q. div_q = all-ones is legal.
  - phase is log2(OS) bits and wraps naturally.
- No combinational path from any input to any output.

Test Plan:
- Reset default: rst held for 3 cycles, then released with en=1 and DEFAULT_DIV=650.
  - Required: div_q=650 and all pulses 0 during reset.
  - First os_tick at cycle 651. First bit_mid at 5208. First bit_end at 10416.
- Runtime divisor: div_load with div_in=3, en=1, OS=16.
  - Required: os_tick every 4 clocks. bit_mid at cycles 32, 96, 160 after the load. bit_end at 64, 128 after the load.
  - bit_mid and bit_end never overlap.
- Resync mid-bit: D=3, assert sync 10 clocks after a bit_end.
  - Required: phase=0 next cycle and no pulse in the sync cycle.
  - Next bit_mid exactly 32 clocks after sync. Next bit_end exactly 64 clocks after sync.
- Enable gating: D=3, drop en for 7 cycles at phase=5 with the prescaler at 2.
  - Required: no pulses while en is low and the counters are frozen.
  - The os_tick after en returns high arrives 2 clocks after re-enable, because the prescaler resumes from 2 and wraps at 3.
- Edge cases:
  - div_in=0: os_tick high every cycle, bit_end every 16 cycles.
  - div_load and sync asserted together: a single restart, div_q updated.
  - rst asserted on a cycle where bit_end is due: bit_end stays 0 and the state clears.
